streamer_seq_checker: RTL and testbench

Synthesizable receive-side checker for the streamer data path. It sits on the client side of `rx_streamer`, throttles `rx_dreq`, and verifies that received records form a contiguous up-counting sequence. It counts good records, bad records and lost-frame events, and can optionally track min/max frame latency. It is the on-chip counterpart of the counter-pattern source that feeds `tx_streamer`, so hardware link tests run without a host bench.

---
 rtl/streamer_seq_checker_pkg.sv | 21 ++
 rtl/streamer_dreq_lfsr.sv | 38 +++
 rtl/streamer_seq_checker.sv | 144 ++++++++++++++
 tb/tb_streamer_seq_checker.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/streamer_seq_checker_pkg.sv
// Shared types and helpers for the streamer receive-side sequence checker
// and its dreq throttle.
package streamer_seq_checker_pkg;

  typedef enum logic {
    S_UNLOCKED = 1'b0,
    S_TRACK    = 1'b1
  } t_chk_state;

  // Galois taps for x^16+x^14+x^13+x^11+1 in a right-shifting register.
  localparam logic [15:0] LfsrPoly        = 16'hB400;
  localparam logic [15:0] LfsrSeedDefault = 16'hACE1;

  // Increment that sticks at the all-ones value of a width-bit counter (width <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_value;
    max_value = (width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
    return (value >= max_value) ? max_value : value + 64'd1;
  endfunction

endpackage

// File: rtl/streamer_dreq_lfsr.sv
// LFSR-driven request throttle: dreq is asserted with probability thresh/256.
// Shared with the source-side counter-pattern generator.
module streamer_dreq_lfsr
  import streamer_seq_checker_pkg::*;
#(
  parameter int unsigned g_dreq_thresh = 205,
  parameter logic [15:0] g_lfsr_seed   = LfsrSeedDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic dreq
);

  // Thresholds above 256 behave as always-on.
  localparam logic [8:0] Thresh = 9'((g_dreq_thresh > 256) ? 256 : g_dreq_thresh);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LfsrPoly;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= g_lfsr_seed;
      dreq   <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      dreq   <= enable && ({1'b0, lfsr_q[7:0]} < Thresh);
    end
  end

endmodule

// File: rtl/streamer_seq_checker.sv
// Receive-side checker for the streamer link: throttles rx_dreq and verifies an
// up-counting record sequence. STREAMER_SEQ_CHECKER_LATENCY_EN adds latency min/max tracking.
module streamer_seq_checker
  import streamer_seq_checker_pkg::*;
#(
  parameter int unsigned g_data_width  = 64,
  parameter int unsigned g_cnt_width   = 32,
  parameter int unsigned g_dreq_thresh = 205,
  parameter logic [15:0] g_lfsr_seed   = LfsrSeedDefault
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  input  logic                    clr_i,
  input  logic [g_data_width-1:0] rx_data_i,
  input  logic                    rx_valid_i,
  output logic                    rx_dreq_o,
  input  logic                    rx_lost_i,
  input  logic [27:0]             rx_latency_i,
  input  logic                    rx_latency_valid_i,
  output logic                    locked_o,
  output logic [g_data_width-1:0] exp_o,
  output logic [g_cnt_width-1:0]  rcvd_cnt_o,
  output logic [g_cnt_width-1:0]  err_cnt_o,
  output logic [g_cnt_width-1:0]  lost_cnt_o,
  output logic                    err_o,
  output logic [27:0]             lat_min_o,
  output logic [27:0]             lat_max_o,
  output logic                    lat_valid_o
);

  localparam logic [g_data_width-1:0] DataOne = {{(g_data_width-1){1'b0}}, 1'b1};

  function automatic logic [g_cnt_width-1:0] cnt_inc(input logic [g_cnt_width-1:0] cnt);
    return g_cnt_width'(sat_inc(64'(cnt), g_cnt_width));
  endfunction

  t_chk_state              state_q;
  logic                    resync_q;
  logic [g_data_width-1:0] exp_q;
  logic [g_cnt_width-1:0]  rcvd_q;
  logic [g_cnt_width-1:0]  err_cnt_q;
  logic [g_cnt_width-1:0]  lost_q;
  logic                    err_q;

  streamer_dreq_lfsr #(
    .g_dreq_thresh (g_dreq_thresh),
    .g_lfsr_seed   (g_lfsr_seed)
  ) u_dreq_lfsr (
    .clk    (clk_sys_i),
    .rst_n  (rst_n_i),
    .enable (enable_i),
    .dreq   (rx_dreq_o)
  );

  // Later assignments deliberately override earlier ones: lost sets resync after
  // the record was checked with the old flag, and clear beats any counter event.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_UNLOCKED;
      resync_q  <= 1'b0;
      exp_q     <= '0;
      rcvd_q    <= '0;
      err_cnt_q <= '0;
      lost_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (!enable_i) begin
        state_q  <= S_UNLOCKED;
        resync_q <= 1'b0;
      end else begin
        if (rx_valid_i) begin
          if (state_q == S_UNLOCKED || resync_q) begin
            exp_q    <= rx_data_i + DataOne;
            rcvd_q   <= cnt_inc(rcvd_q);
            state_q  <= S_TRACK;
            resync_q <= 1'b0;
          end else if (rx_data_i == exp_q) begin
            exp_q  <= exp_q + DataOne;
            rcvd_q <= cnt_inc(rcvd_q);
          end else begin
            exp_q     <= rx_data_i + DataOne;
            err_cnt_q <= cnt_inc(err_cnt_q);
            err_q     <= 1'b1;
          end
        end
        if (rx_lost_i) begin
          lost_q   <= cnt_inc(lost_q);
          resync_q <= 1'b1;
        end
      end
      if (clr_i) begin
        rcvd_q    <= '0;
        err_cnt_q <= '0;
        lost_q    <= '0;
      end
    end
  end

  assign locked_o   = (state_q == S_TRACK);
  assign exp_o      = exp_q;
  assign rcvd_cnt_o = rcvd_q;
  assign err_cnt_o  = err_cnt_q;
  assign lost_cnt_o = lost_q;
  assign err_o      = err_q;

`ifdef STREAMER_SEQ_CHECKER_LATENCY_EN
  logic [27:0] lat_min_q;
  logic [27:0] lat_max_q;
  logic        lat_valid_q;

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lat_min_q   <= 28'hFFF_FFFF;
      lat_max_q   <= '0;
      lat_valid_q <= 1'b0;
    end else if (clr_i) begin
      lat_min_q   <= 28'hFFF_FFFF;
      lat_max_q   <= '0;
      lat_valid_q <= 1'b0;
    end else if (rx_latency_valid_i) begin
      if (rx_latency_i < lat_min_q) begin
        lat_min_q <= rx_latency_i;
      end
      if (rx_latency_i > lat_max_q) begin
        lat_max_q <= rx_latency_i;
      end
      lat_valid_q <= 1'b1;
    end
  end

  assign lat_min_o   = lat_min_q;
  assign lat_max_o   = lat_max_q;
  assign lat_valid_o = lat_valid_q;
`else
  logic unused_lat;
  assign unused_lat  = ^{rx_latency_i, rx_latency_valid_i};
  assign lat_min_o   = '0;
  assign lat_max_o   = '0;
  assign lat_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_streamer_seq_checker.sv
// Self-checking bench for streamer_seq_checker: directed table, corner sequences
// and randomized traffic against a behavioural sequence model.
module tb_streamer_seq_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, clr, valid, lost, lat_v;
  logic [63:0] data;
  logic [27:0] lat;

  logic        dreq, locked, err;
  logic [63:0] exp_o;
  logic [31:0] rcvd, errc, lostc;
  logic [27:0] lmin, lmax;
  logic        lval;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit              m_locked, m_resync, m_err, m_dreq_low;
  logic [63:0]     m_exp;
  longint unsigned m_rcvd, m_errc, m_lost;
  logic [27:0]     m_lmin, m_lmax;
  bit              m_lval;

  typedef struct {
    bit          v;
    logic [63:0] d;
    bit          l;
    bit          c;
    bit          e;
    bit          x_lock;
    bit          x_err;
    logic [63:0] x_exp;
    int unsigned x_rcvd;
    int unsigned x_errc;
    int unsigned x_lost;
  } vec_t;

  vec_t tbl[19];

  streamer_seq_checker dut (
    .clk_sys_i          (clk),
    .rst_n_i            (rst_n),
    .enable_i           (en),
    .clr_i              (clr),
    .rx_data_i          (data),
    .rx_valid_i         (valid),
    .rx_dreq_o          (dreq),
    .rx_lost_i          (lost),
    .rx_latency_i       (lat),
    .rx_latency_valid_i (lat_v),
    .locked_o           (locked),
    .exp_o              (exp_o),
    .rcvd_cnt_o         (rcvd),
    .err_cnt_o          (errc),
    .lost_cnt_o         (lostc),
    .err_o              (err),
    .lat_min_o          (lmin),
    .lat_max_o          (lmax),
    .lat_valid_o        (lval)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint unsigned sat32(input longint unsigned v);
    return (v >= 64'hFFFF_FFFF) ? v : v + 1;
  endfunction

  function automatic vec_t mk(input int v, input longint unsigned d, input int l, input int c,
                              input int e, input int xl, input int xe, input longint unsigned xx,
                              input int xr, input int xc, input int xo);
    vec_t r;
    r.v = (v != 0);  r.d = d;  r.l = (l != 0);  r.c = (c != 0);  r.e = (e != 0);
    r.x_lock = (xl != 0);  r.x_err = (xe != 0);  r.x_exp = xx;
    r.x_rcvd = xr;  r.x_errc = xc;  r.x_lost = xo;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;  m_resync = 0;  m_err = 0;  m_dreq_low = 1;
    m_exp = '0;  m_rcvd = 0;  m_errc = 0;  m_lost = 0;
    m_lmin = 28'hFFF_FFFF;  m_lmax = '0;  m_lval = 0;
  endtask

  // One clock edge worth of the checker's rules, applied to the sampled inputs.
  task automatic model_step();
    m_err = 0;
    if (en) begin
      if (valid) begin
        if (!m_locked || m_resync) begin
          m_exp = data + 64'd1;  m_locked = 1;  m_resync = 0;  m_rcvd = sat32(m_rcvd);
        end else if (data == m_exp) begin
          m_exp = m_exp + 64'd1;  m_rcvd = sat32(m_rcvd);
        end else begin
          m_err = 1;  m_errc = sat32(m_errc);  m_exp = data + 64'd1;
        end
      end
      if (lost) begin
        m_lost = sat32(m_lost);  m_resync = 1;
      end
    end else begin
      m_locked = 0;  m_resync = 0;
    end
    if (clr) begin
      m_rcvd = 0;  m_errc = 0;  m_lost = 0;
    end
    if (clr) begin
      m_lmin = 28'hFFF_FFFF;  m_lmax = '0;  m_lval = 0;
    end else if (lat_v) begin
      m_lmin = (lat < m_lmin) ? lat : m_lmin;
      m_lmax = (lat > m_lmax) ? lat : m_lmax;
      m_lval = 1;
    end
    m_dreq_low = !en;
  endtask

  task automatic check_all();
    check("locked", 64'(locked), 64'(m_locked));
    check("exp", exp_o, m_exp);
    check("rcvd_cnt", 64'(rcvd), m_rcvd);
    check("err_cnt", 64'(errc), m_errc);
    check("lost_cnt", 64'(lostc), m_lost);
    check("err_pulse", 64'(err), 64'(m_err));
    if (m_dreq_low) check("dreq_off", 64'(dreq), 64'd0);
`ifdef STREAMER_SEQ_CHECKER_LATENCY_EN
    check("lat_min", 64'(lmin), 64'(m_lmin));
    check("lat_max", 64'(lmax), 64'(m_lmax));
    check("lat_valid", 64'(lval), 64'(m_lval));
`else
    check("lat_min_tied", 64'(lmin), 64'd0);
    check("lat_max_tied", 64'(lmax), 64'd0);
    check("lat_valid_tied", 64'(lval), 64'd0);
`endif
  endtask

  task automatic cycle(input bit chk);
    @(posedge clk);
    model_step();
    #1;
    if (chk) check_all();
  endtask

  initial begin
    bit              seen, prev;
    int              ones;
    longint unsigned rc_before;
    logic [63:0]     src;

    en = 1;  clr = 0;  valid = 0;  data = '0;  lost = 0;  lat_v = 0;  lat = '0;
    rst_n = 0;
    model_reset();
    #12;
    check("reset_dreq", 64'(dreq), 64'd0);
    check_all();
    @(negedge clk);
    rst_n = 1;

    // Contiguous stream 0..999
    for (int i = 0; i < 1000; i++) begin
      valid = 1;  data = 64'(i);
      cycle(1);
    end
    valid = 0;
    cycle(1);
    check("contig_rcvd", 64'(rcvd), 64'd1000);
    check("contig_err", 64'(errc), 64'd0);
    check("contig_exp", exp_o, 64'd1000);
    check("contig_locked", 64'(locked), 64'd1);

    // Asynchronous reset in the middle of a stream
    valid = 1;  data = 64'd1000;
    cycle(1);
    rst_n = 0;
    model_reset();
    #1;
    check("rst_async_dreq", 64'(dreq), 64'd0);
    check("rst_async_rcvd", 64'(rcvd), 64'd0);
    check("rst_async_locked", 64'(locked), 64'd0);
    check_all();
    valid = 0;
    #2;
    rst_n = 1;

    // Directed table from a fresh reset
    tbl[0]  = mk(1, 5, 0, 0, 1,  1, 0, 6, 1, 0, 0);
    tbl[1]  = mk(1, 6, 0, 0, 1,  1, 0, 7, 2, 0, 0);
    tbl[2]  = mk(1, 7, 0, 0, 1,  1, 0, 8, 3, 0, 0);
    tbl[3]  = mk(1, 9, 0, 0, 1,  1, 1, 10, 3, 1, 0);
    tbl[4]  = mk(1, 10, 0, 0, 1, 1, 0, 11, 4, 1, 0);
    tbl[5]  = mk(0, 0, 0, 1, 1,  1, 0, 11, 0, 0, 0);
    tbl[6]  = mk(1, 11, 0, 0, 1, 1, 0, 12, 1, 0, 0);
    tbl[7]  = mk(0, 0, 1, 0, 1,  1, 0, 12, 1, 0, 1);
    tbl[8]  = mk(1, 28, 0, 0, 1, 1, 0, 29, 2, 0, 1);
    tbl[9]  = mk(1, 29, 0, 0, 1, 1, 0, 30, 3, 0, 1);
    tbl[10] = mk(1, 30, 1, 0, 1, 1, 0, 31, 4, 0, 2);
    tbl[11] = mk(1, 50, 0, 0, 1, 1, 0, 51, 5, 0, 2);
    tbl[12] = mk(1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 5, 1, 2);
    tbl[13] = mk(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 1, 0, 0, 6, 1, 2);
    tbl[14] = mk(1, 0, 0, 0, 1,  1, 0, 1, 7, 1, 2);
    tbl[15] = mk(1, 1, 0, 0, 1,  1, 0, 2, 8, 1, 2);
    tbl[16] = mk(1, 77, 0, 0, 0, 0, 0, 2, 8, 1, 2);
    tbl[17] = mk(1, 100, 0, 0, 1, 1, 0, 101, 9, 1, 2);
    tbl[18] = mk(1, 101, 0, 1, 1, 1, 0, 102, 0, 0, 0);
    for (int i = 0; i < 19; i++) begin
      valid = tbl[i].v;  data = tbl[i].d;  lost = tbl[i].l;  clr = tbl[i].c;  en = tbl[i].e;
      cycle(0);
      check($sformatf("tbl%0d_locked", i), 64'(locked), 64'(tbl[i].x_lock));
      check($sformatf("tbl%0d_err", i), 64'(err), 64'(tbl[i].x_err));
      check($sformatf("tbl%0d_exp", i), exp_o, tbl[i].x_exp);
      check($sformatf("tbl%0d_rcvd", i), 64'(rcvd), 64'(tbl[i].x_rcvd));
      check($sformatf("tbl%0d_errc", i), 64'(errc), 64'(tbl[i].x_errc));
      check($sformatf("tbl%0d_lost", i), 64'(lostc), 64'(tbl[i].x_lost));
    end
    valid = 0;  lost = 0;  clr = 0;  en = 1;

    // Latency extrema
    lat_v = 1;
    lat = 28'd500;  cycle(1);
    lat = 28'd120;  cycle(1);
    lat = 28'd900;  cycle(1);
    lat_v = 0;
`ifdef STREAMER_SEQ_CHECKER_LATENCY_EN
    check("lat_min_120", 64'(lmin), 64'd120);
    check("lat_max_900", 64'(lmax), 64'd900);
    check("lat_valid_set", 64'(lval), 64'd1);
`endif
    clr = 1;  cycle(1);  clr = 0;
`ifdef STREAMER_SEQ_CHECKER_LATENCY_EN
    check("lat_min_clr", 64'(lmin), 64'hFFF_FFFF);
    check("lat_max_clr", 64'(lmax), 64'd0);
    check("lat_valid_clr", 64'(lval), 64'd0);
`endif

    // Record delivered in the cycle after dreq falls is still counted
    seen = 0;
    for (int k = 0; k < 500 && !seen; k++) begin
      prev = dreq;
      cycle(0);
      if (prev && !dreq) seen = 1;
    end
    check("dreq_fall_seen", 64'(seen), 64'd1);
    if (seen) begin
      valid = 1;  data = m_exp;  rc_before = m_rcvd;
      cycle(1);
      check("late_record_counted", 64'(rcvd), rc_before + 1);
      valid = 0;
    end

    // Throttle duty over 10000 cycles
    ones = 0;
    for (int k = 0; k < 10000; k++) begin
      cycle(0);
      ones += int'(dreq);
    end
    check("dreq_duty_77_83pct", 64'(ones >= 7700 && ones <= 8300), 64'd1);

    // Randomized traffic against the model
    src = 64'hFFFF_FFFF_FFFF_FF00;
    for (int k = 0; k < 3000; k++) begin
      valid = ($urandom_range(9) < 6);
      if ($urandom_range(99) < 4) data = {$urandom, $urandom};
      else data = src;
      if (valid) src = data + 64'd1;
      lost  = ($urandom_range(49) == 0);
      clr   = ($urandom_range(99) == 0);
      en    = ($urandom_range(49) != 0);
      lat_v = ($urandom_range(3) == 0);
      lat   = 28'($urandom);
      cycle(1);
    end
    valid = 0;  lost = 0;  clr = 0;  en = 1;  lat_v = 0;
    cycle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
